// File: rtl/activation_sequencer.sv
// Gathers a scalar stream into VECTOR_LEN chunks for a shared combinational activation unit, then re-serialises the results.
// Latency: two cycles from a chunk's last input to its first output; each side uses valid/ready and holds its output while stalled.
module activation_sequencer #(
  parameter int VECTOR_LEN = 3,
  parameter int LEN_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         num_values,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic [VECTOR_LEN*32-1:0] act_data_in,
  input  logic [VECTOR_LEN*32-1:0] act_data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last
);

  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int CNT_W = $clog2(VECTOR_LEN + 1);
  localparam logic [LEN_W-1:0] VL_LEN  = LEN_W'(VECTOR_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_APPLY,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LEN_W-1:0]             r_remaining;
  logic [IDX_W-1:0]             r_fill_idx;
  logic [IDX_W-1:0]             r_drain_idx;
  logic [CNT_W-1:0]             r_chunk_n;
  logic [VECTOR_LEN-1:0][31:0]  r_in_buf;
  logic [VECTOR_LEN-1:0][31:0]  r_out_buf;
  logic                         r_done;

  logic [CNT_W-1:0]             w_fill_n;
  logic                         w_fill_last;
  logic                         w_drain_last;
  logic                         w_final_value;

  // remaining only moves on output handshakes, so it is stable for the whole FILL phase
  assign w_fill_n      = (r_remaining >= VL_LEN) ? CNT_W'(VECTOR_LEN) : CNT_W'(r_remaining);
  assign w_fill_last   = (CNT_W'(r_fill_idx) == (w_fill_n - CNT_W'(1)));
  assign w_drain_last  = (CNT_W'(r_drain_idx) == (r_chunk_n - CNT_W'(1)));
  assign w_final_value = (r_remaining == LEN_ONE);

  assign act_data_in = r_in_buf;
  assign out_data    = r_out_buf[r_drain_idx];
  assign done        = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (num_values != '0)) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && w_fill_last) begin
          w_next = S_APPLY;
        end
      end
      S_APPLY: begin
        busy   = 1'b1;
        w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_drain_last && w_final_value;
        if (out_ready && w_drain_last) begin
          w_next = w_final_value ? S_IDLE : S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Clearing the input buffer at every chunk start provides the zero padding for short final chunks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_fill_idx  <= '0;
      r_drain_idx <= '0;
      r_chunk_n   <= '0;
      r_in_buf    <= '0;
      r_out_buf   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_values == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= num_values;
              r_fill_idx  <= '0;
              r_in_buf    <= '0;
            end
          end
        end
        S_FILL: begin
          if (in_valid) begin
            r_in_buf[r_fill_idx] <= in_data;
            r_fill_idx           <= r_fill_idx + IDX_W'(1);
            if (w_fill_last) begin
              r_chunk_n <= w_fill_n;
            end
          end
        end
        S_APPLY: begin
          r_out_buf   <= act_data_out;
          r_drain_idx <= '0;
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_remaining <= r_remaining - LEN_ONE;
            r_drain_idx <= r_drain_idx + IDX_W'(1);
            if (w_drain_last) begin
              if (w_final_value) begin
                r_done <= 1'b1;
              end else begin
                r_fill_idx <= '0;
                r_in_buf   <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_sequencer.sv
// Randomised bench for activation_sequencer with a relu unit and a queue-based reference model.
module tb_activation_sequencer;
  localparam int VL = 3;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   num_values;
  logic            busy;
  logic            done;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic [VL*32-1:0] act_data_in;
  logic [VL*32-1:0] act_data_out;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_last;

  always #5 clk = ~clk;

  activation_sequencer #(.VECTOR_LEN(VL), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_values(num_values),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .act_data_in(act_data_in), .act_data_out(act_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  // shared relu unit
  always_comb begin
    act_data_out = '0;
    for (int i = 0; i < VL; i++) begin
      act_data_out[32*i +: 32] = act_data_in[32*i+31] ? 32'd0 : act_data_in[32*i +: 32];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int               stim[$];
  logic [31:0]      exp_dat_q[$];
  bit               exp_last_q[$];
  logic [VL*32-1:0] exp_apply_q[$];
  int  done_cnt = 0;
  int  ncyc = 0;
  int  done_ref = -100;
  bit  mon_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic load_model(input int n);
    logic [VL*32-1:0] ch;
    for (int i = 0; i < n; i++) begin
      exp_dat_q.push_back(32'(relu(stim[i])));
      exp_last_q.push_back(i == n - 1);
    end
    for (int c = 0; c * VL < n; c++) begin
      ch = '0;
      for (int l = 0; l < VL; l++) begin
        if (c * VL + l < n) ch[32*l +: 32] = stim[c*VL + l];
      end
      exp_apply_q.push_back(ch);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ed;
    bit el;
    ncyc++;
    if (done) done_cnt++;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (done) check_eq("done_latency", ncyc - done_ref, 1);
      if (start && !busy && num_values == '0) done_ref = ncyc;
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_data", out_data, prev_dat);
      end
      if (out_valid && out_ready) begin
        if (exp_dat_q.size() == 0) begin
          check_eq("extra_output", 1, 0);
        end else begin
          ed = exp_dat_q.pop_front();
          el = exp_last_q.pop_front();
          check_eq("out_data", out_data, ed);
          check_eq("out_last", out_last, el);
          if (el) done_ref = ncyc;
        end
      end
      if (busy && !in_ready && !out_valid) begin
        if (exp_apply_q.size() == 0) check_eq("extra_apply", 1, 0);
        else check_eq("apply_chunk", act_data_in, exp_apply_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
    end
  end

  task automatic feed(input bit gap);
    for (int i = 0; i < stim.size(); i++) begin
      bit took;
      int t;
      if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = stim[i];
      took = 1'b0;
      t = 0;
      while (!took && t < 200) begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk); #1;
        t++;
      end
      in_valid = 1'b0;
      if (!took) begin
        check_eq("feed_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic sink(input bit bp);
    int t = 0;
    while (exp_dat_q.size() > 0 && t < 2000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b0;
    if (t >= 2000) check_eq("sink_timeout", 0, 1);
  endtask

  task automatic poke();
    int t = 0;
    while (!out_valid && t < 500) begin @(posedge clk); #1; t++; end
    check_eq("poke_in_drain", out_valid, 1'b1);
    start = 1'b1;
    num_values = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    num_values = '0;
  endtask

  task automatic run(input int n, input bit gap, input bit bp, input bit poke_en);
    int d0;
    int t;
    load_model(n);
    d0 = done_cnt;
    start = 1'b1;
    num_values = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, n != 0);
    if (n == 0) begin
      check_eq("zero_in_ready", in_ready, 1'b0);
      check_eq("zero_out_valid", out_valid, 1'b0);
    end
    fork
      feed(gap);
      sink(bp);
      begin if (poke_en) poke(); end
    join
    t = 0;
    while (done_cnt == d0 && t < 50) begin @(posedge clk); #1; t++; end
    repeat (3) begin @(posedge clk); #1; end
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("busy_end", busy, 1'b0);
    check_eq("leftover_out", exp_dat_q.size(), 0);
    check_eq("leftover_apply", exp_apply_q.size(), 0);
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(int'($urandom()));
  endtask

  initial begin
    int d0;
    int t;
    rst_n = 1'b0; start = 1'b0; num_values = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_act_in", act_data_in, '0);
    check_eq("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    stim = '{5, -2, 7};
    run(3, 1'b0, 1'b0, 1'b0);
    stim = '{1, -2, 3, -4, 5, -6, 7};
    run(7, 1'b0, 1'b0, 1'b0);
    stim.delete();
    run(0, 1'b0, 1'b0, 1'b0);
    rand_stim(8);
    run(8, 1'b1, 1'b1, 1'b0);
    rand_stim(4);
    run(4, 1'b1, 1'b0, 1'b1);

    // abandon a run in its second DRAIN cycle
    stim = '{4, 8, -3};
    load_model(3);
    d0 = done_cnt;
    start = 1'b1; num_values = LW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    feed(1'b0);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    check_eq("rst_mid_in_drain", out_valid, 1'b1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_out_valid", out_valid, 1'b0);
    check_eq("rst_mid_act_in", act_data_in, '0);
    check_eq("rst_mid_out_data", out_data, '0);
    check_eq("rst_mid_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check_eq("rst_mid_no_done", done_cnt - d0, 0);
    exp_dat_q.delete();
    exp_last_q.delete();
    exp_apply_q.delete();
    mon_en = 1'b1;
    stim = '{-1, 9};
    run(2, 1'b0, 1'b0, 1'b0);

    rand_stim(6);
    run(6, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 10);
      rand_stim(n);
      run(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/activation_sequencer.md
Name: activation_sequencer

Overview:
- Sequences a layer's output stream through one shared, combinational, VECTOR_LEN-wide activation unit (e.g. relu).
- Collects scalar pre-activation values one per cycle into a VECTOR_LEN chunk and presents the chunk to the unit.
- Captures the unit's result and re-serialises it downstream.
- Sits between a layer's accumulator output and the next layer's input buffer; handles arbitrary layer lengths, including partial final chunks.

Parameters:
- VECTOR_LEN, 3, number of lanes of the shared activation unit (>=1).
- LEN_W, 16, width of the per-run value count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse; begins a run, sampled only in IDLE.
- num_values  input  LEN_W  values in the run, sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the run completes.
- in_valid  input  1  upstream value valid.
- in_ready  output  1  sequencer can accept a value.
- in_data  input  32  signed pre-activation value.
- act_data_in  output  VECTOR_LEN*32  chunk to the activation unit; lane i occupies bits [32i+31:32i].
- act_data_out  input  VECTOR_LEN*32  activation unit result, combinational from act_data_in.
- out_valid  output  1  downstream value valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32  signed activated value.
- out_last  output  1  marks the final value of the run, qualified by out_valid.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; chunk counters and total counters clear.
  - Input and output chunk buffers clear to 0.
  - busy, done, in_ready, out_valid and out_last are 0; act_data_in is 0; out_data is 0.
  - Reset mid-run abandons the run with no done pulse; upstream and downstream must also be reset.
- State IDLE:
  - in_ready=0.
  - start=1 with num_values>0: latch remaining=num_values, go to FILL.
  - start=1 with num_values=0: pulse done next cycle, stay IDLE, no output.
  - start in any other state is ignored.
- State FILL:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_data to lane fill_idx and increments fill_idx.
  - Go to APPLY on the handshake that fills lane VECTOR_LEN-1, or on the handshake that consumes the last remaining value.
  - Chunk size n = min(VECTOR_LEN, remaining at chunk start).
  - Lanes >= n are forced to 0 (zero padding). Stale data never reaches the unit.
- State APPLY, exactly one cycle:
  - in_ready=0.
  - act_data_in is driven directly from the input buffer register at all times (no mux glitching on state).
  - At the end of the APPLY cycle, act_data_out is registered into the output buffer. Go to DRAIN with drain_idx=0.
- State DRAIN:
  - out_valid=1; out_data = output buffer lane drain_idx.
  - out_last=1 when drain_idx==n-1 and this is the final chunk.
  - On out_valid&&out_ready: drain_idx increments and remaining decrements.
  - After lane n-1 is accepted:
    - remaining>0: go to FILL with fill_idx=0.
    - otherwise: go to IDLE and pulse done in the same cycle as the transition edge (done high in the first IDLE cycle).
  - Padded lanes are never emitted.
  - out_valid/out_data stay stable while out_ready=0 (AXI-stream rule).
- busy=1 in FILL, APPLY and DRAIN.
- Timing:
  - Minimum latency from the last input handshake of a chunk to the first out_valid: 2 cycles (APPLY, then DRAIN).
  - Throughput with no stalls: VECTOR_LEN inputs, 1 apply cycle, VECTOR_LEN outputs per chunk.
- remaining and counters are LEN_W wide; num_values up to 2^LEN_W-1 must not wrap.
- Data is passed bit-exact; the sequencer performs no arithmetic on values.

Test Plan:
- VECTOR_LEN=3, num_values=3, inputs {5,-2,7}, unit=relu -> outputs {5,0,7}; out_last on the third output; done one cycle after the last accept; act_data_in lanes 5,-2,7 during APPLY.
- num_values=7, inputs 1..7 with sign alternating (1,-2,3,-4,5,-6,7) -> outputs {1,0,3,0,5,0,7}; three APPLY cycles; final chunk lanes 1,2 of act_data_in equal 0; out_last only on value 7.
- num_values=0 with start -> done high exactly one cycle later; busy stays 0; no in_ready and no out_valid.
- Backpressure: out_ready toggled 0/1 randomly and in_valid gapped -> output sequence unchanged, out_data stable while stalled, no value dropped or duplicated.
- start pulsed again during DRAIN of a num_values=4 run -> ignored; exactly 4 outputs, single done.
- rst_n driven low in the second cycle of DRAIN -> next cycle busy=0, out_valid=0, act_data_in=0, no done. A fresh num_values=2 run {-1,9} then yields {0,9}.
